// File: rtl/sram_req_arbiter_if.sv
// SRAM-like request/response link: master drives the request fields, slave returns addr_ok/data_ok/rdata.
// Combinational handshake; one request per cycle and in-order responses.
interface sram_req_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req;
    logic                  wr;
    logic [1:0]            size;
    logic [DATA_W/8-1:0]   wstrb;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic                  addr_ok;
    logic                  data_ok;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between inst and data masters; 0-cycle request path, grant held until addr_ok, full owner FIFO stalls both.
// Default build uses fixed data>inst priority; define ARB_RR_EN for round-robin arbitration.
module sram_req_arbiter #(
    parameter int OUTSTANDING = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              resetn,
    sram_req_arbiter_if.slave  inst_bus,
    sram_req_arbiter_if.slave  data_bus,
    sram_req_arbiter_if.master m_bus
);
    localparam int              PTR_W    = $clog2(OUTSTANDING);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(OUTSTANDING);
    localparam logic            OWN_INST = 1'b0;
    localparam logic            OWN_DATA = 1'b1;

    logic [OUTSTANDING-1:0] r_own;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [PTR_W:0]         r_count;
    logic                   r_lock;
    logic                   r_lock_owner;
    logic                   r_err_orphan;
`ifdef ARB_RR_EN
    logic                   r_rr_last;
`endif

    logic w_full;
    logic w_win;
    logic w_win_req;
    logic w_push;
    logic w_pop;
    logic w_head;

    assign w_full = (r_count == FULL_CNT);

    // A locked grant sticks to its owner until the downstream accepts it.
    always_comb begin
        w_win = OWN_INST;
        if (r_lock) begin
            w_win = r_lock_owner;
        end else if (data_bus.req && inst_bus.req) begin
`ifdef ARB_RR_EN
            w_win = ~r_rr_last;
`else
            w_win = OWN_DATA;
`endif
        end else if (data_bus.req) begin
            w_win = OWN_DATA;
        end
    end

    assign w_win_req = w_win ? data_bus.req : inst_bus.req;

    assign m_bus.req   = resetn & w_win_req & ~w_full;
    assign m_bus.wr    = w_win ? data_bus.wr    : inst_bus.wr;
    assign m_bus.size  = w_win ? data_bus.size  : inst_bus.size;
    assign m_bus.wstrb = w_win ? data_bus.wstrb : inst_bus.wstrb;
    assign m_bus.addr  = w_win ? data_bus.addr  : inst_bus.addr;
    assign m_bus.wdata = w_win ? data_bus.wdata : inst_bus.wdata;

    assign w_push = m_bus.req & m_bus.addr_ok;
    assign w_pop  = resetn & m_bus.data_ok & (r_count != '0);
    assign w_head = r_own[r_rd_ptr];

    assign inst_bus.addr_ok = w_push & (w_win == OWN_INST);
    assign data_bus.addr_ok = w_push & (w_win == OWN_DATA);

    assign inst_bus.data_ok = w_pop & (w_head == OWN_INST);
    assign data_bus.data_ok = w_pop & (w_head == OWN_DATA);
    assign inst_bus.rdata   = m_bus.rdata;
    assign data_bus.rdata   = m_bus.rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_lock       <= 1'b0;
            r_lock_owner <= OWN_INST;
            r_err_orphan <= 1'b0;
`ifdef ARB_RR_EN
            r_rr_last    <= OWN_INST;
`endif
        end else begin
            if (w_push) begin
                r_own[r_wr_ptr] <= w_win;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PTR_W+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (PTR_W+1)'(1);
            end

            // An owner that withdraws its request mid-lock releases the grant.
            if (m_bus.req && !m_bus.addr_ok) begin
                r_lock       <= 1'b1;
                r_lock_owner <= w_win;
            end else if (w_push) begin
                r_lock <= 1'b0;
            end else if (r_lock && !w_win_req) begin
                r_lock <= 1'b0;
            end

            r_err_orphan <= r_err_orphan | (m_bus.data_ok && (r_count == '0));
`ifdef ARB_RR_EN
            if (w_push) begin
                r_rr_last <= w_win;
            end
`endif
        end
    end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: grant priority/lock, in-order routing, full stall and reset flush.
module tb_sram_req_arbiter;
    logic clk;
    logic resetn;
    int   n_checks;
    int   n_fail;
    logic exp_w [4];

    sram_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_if ();
    sram_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_if ();
    sram_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m_if ();

    sram_req_arbiter #(.OUTSTANDING(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .inst_bus (inst_if),
        .data_bus (data_if),
        .m_bus    (m_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_inst(input logic req, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        inst_if.req   = req;
        inst_if.wr    = wr;
        inst_if.size  = 2'd2;
        inst_if.wstrb = wr ? 4'hF : 4'h0;
        inst_if.addr  = addr;
        inst_if.wdata = wdata;
    endtask

    task automatic drv_data(input logic req, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        data_if.req   = req;
        data_if.wr    = wr;
        data_if.size  = 2'd2;
        data_if.wstrb = wr ? 4'hF : 4'h0;
        data_if.addr  = addr;
        data_if.wdata = wdata;
    endtask

    task automatic drv_m(input logic addr_ok, input logic data_ok, input logic [31:0] rdata);
        m_if.addr_ok = addr_ok;
        m_if.data_ok = data_ok;
        m_if.rdata   = rdata;
    endtask

    task automatic idle();
        drv_inst(1'b0, 1'b0, 32'h0, 32'h0);
        drv_data(1'b0, 1'b0, 32'h0, 32'h0);
        drv_m(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset: outputs quiet even with every input asserted
        resetn = 1'b0;
        drv_inst(1'b1, 1'b0, 32'h10, 32'h0);
        drv_data(1'b1, 1'b0, 32'h20, 32'h0);
        drv_m(1'b1, 1'b1, 32'hFFFF);
        repeat (2) step();
        chk("rst_m_req", m_if.req, 0);
        chk("rst_inst_addr_ok", inst_if.addr_ok, 0);
        chk("rst_data_addr_ok", data_if.addr_ok, 0);
        chk("rst_inst_data_ok", inst_if.data_ok, 0);
        chk("rst_data_data_ok", data_if.data_ok, 0);
        idle();
        resetn = 1'b1;
        step();
        chk("idle_m_req", m_if.req, 0);

        // 1: single fetch, response next cycle
        drv_inst(1'b1, 1'b0, 32'h1c000000, 32'h0);
        drv_m(1'b1, 1'b0, 32'h0);
        #1;
        chk("t1_m_req", m_if.req, 1);
        chk("t1_m_addr", m_if.addr, 32'h1c000000);
        chk("t1_inst_addr_ok", inst_if.addr_ok, 1);
        chk("t1_data_addr_ok", data_if.addr_ok, 0);
        step();
        idle();
        drv_m(1'b0, 1'b1, 32'h02c00000);
        #1;
        chk("t1_inst_data_ok", inst_if.data_ok, 1);
        chk("t1_inst_rdata", inst_if.rdata, 32'h02c00000);
        chk("t1_data_data_ok", data_if.data_ok, 0);
        step();
        idle();

        // 2a: simultaneous requests, data first then inst
        drv_inst(1'b1, 1'b0, 32'hA0, 32'h0);
        drv_data(1'b1, 1'b0, 32'hB0, 32'h0);
        drv_m(1'b1, 1'b0, 32'h0);
        #1;
        chk("t2_data_addr_ok", data_if.addr_ok, 1);
        chk("t2_inst_addr_ok0", inst_if.addr_ok, 0);
        chk("t2_m_addr0", m_if.addr, 32'hB0);
        step();
        drv_data(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("t2_inst_addr_ok1", inst_if.addr_ok, 1);
        chk("t2_m_addr1", m_if.addr, 32'hA0);
        step();
        idle();
        drv_m(1'b0, 1'b1, 32'h11);
        #1;
        chk("t2_data_data_ok", data_if.data_ok, 1);
        chk("t2_data_rdata", data_if.rdata, 32'h11);
        chk("t2_inst_data_ok0", inst_if.data_ok, 0);
        step();
        drv_m(1'b0, 1'b1, 32'h22);
        #1;
        chk("t2_inst_data_ok1", inst_if.data_ok, 1);
        chk("t2_inst_rdata", inst_if.rdata, 32'h22);
        step();
        idle();

        // 2b: four back-to-back contended cycles, each response one cycle after its push
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
            exp_w[k] = (k % 2 == 0);
`else
            exp_w[k] = 1'b1;
`endif
        end
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k < 4) begin
                drv_inst(1'b1, 1'b0, 32'h300 + 32'(k * 4), 32'h0);
                drv_data(1'b1, 1'b0, 32'h200 + 32'(k * 4), 32'h0);
                m_if.addr_ok = 1'b1;
            end
            if (k > 0) begin
                m_if.data_ok = 1'b1;
                m_if.rdata   = 32'h100 + 32'(k);
            end
            #1;
            if (k < 4) begin
                chk("t2b_data_addr_ok", data_if.addr_ok, exp_w[k]);
                chk("t2b_inst_addr_ok", inst_if.addr_ok, !exp_w[k]);
            end
            if (k > 0) begin
                chk("t2b_data_data_ok", data_if.data_ok, exp_w[k-1]);
                chk("t2b_inst_data_ok", inst_if.data_ok, !exp_w[k-1]);
            end
            step();
        end
        idle();

        // 3: stalled store holds the port while inst waits
        drv_data(1'b1, 1'b1, 32'h1000, 32'hDEADBEEF);
        #1;
        chk("t3_m_addr", m_if.addr, 32'h1000);
        chk("t3_m_wr", m_if.wr, 1);
        chk("t3_m_wstrb", m_if.wstrb, 4'hF);
        step();
        drv_inst(1'b1, 1'b0, 32'h2000, 32'h0);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t3_m_addr_held", m_if.addr, 32'h1000);
            chk("t3_inst_addr_ok", inst_if.addr_ok, 0);
            step();
        end
        drv_m(1'b1, 1'b0, 32'h0);
        #1;
        chk("t3_data_addr_ok", data_if.addr_ok, 1);
        chk("t3_m_wdata", m_if.wdata, 32'hDEADBEEF);
        step();
        drv_data(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("t3_inst_after", inst_if.addr_ok, 1);
        chk("t3_m_addr_inst", m_if.addr, 32'h2000);
        step();
        idle();
        drv_m(1'b0, 1'b1, 32'h33);
        #1;
        chk("t3_rsp_data", data_if.data_ok, 1);
        step();
        drv_m(1'b0, 1'b1, 32'h44);
        #1;
        chk("t3_rsp_inst", inst_if.data_ok, 1);
        step();
        idle();

        // 3b: inst lock overrides data priority
        drv_inst(1'b1, 1'b0, 32'h3000, 32'h0);
        #1;
        chk("t3b_m_addr", m_if.addr, 32'h3000);
        step();
        drv_data(1'b1, 1'b0, 32'h4000, 32'h0);
        drv_m(1'b1, 1'b0, 32'h0);
        #1;
        chk("t3b_inst_addr_ok", inst_if.addr_ok, 1);
        chk("t3b_data_addr_ok", data_if.addr_ok, 0);
        chk("t3b_m_addr_lock", m_if.addr, 32'h3000);
        step();
        drv_inst(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("t3b_data_next", data_if.addr_ok, 1);
        step();
        idle();
        drv_m(1'b0, 1'b1, 32'h55);
        #1;
        chk("t3b_rsp_inst", inst_if.data_ok, 1);
        step();
        drv_m(1'b0, 1'b1, 32'h66);
        #1;
        chk("t3b_rsp_data", data_if.data_ok, 1);
        step();
        idle();

        // 3c: locked owner withdraws its request
        drv_data(1'b1, 1'b0, 32'h5000, 32'h0);
        #1;
        chk("t3c_m_req", m_if.req, 1);
        step();
        drv_data(1'b0, 1'b0, 32'h0, 32'h0);
        drv_inst(1'b1, 1'b0, 32'h6000, 32'h0);
        #1;
        chk("t3c_m_req_drop", m_if.req, 0);
        step();
        #1;
        chk("t3c_m_req_inst", m_if.req, 1);
        chk("t3c_m_addr_inst", m_if.addr, 32'h6000);
        step();
        drv_m(1'b1, 1'b0, 32'h0);
        #1;
        chk("t3c_inst_addr_ok", inst_if.addr_ok, 1);
        step();
        idle();
        drv_m(1'b0, 1'b1, 32'h77);
        #1;
        chk("t3c_rsp_inst", inst_if.data_ok, 1);
        step();
        idle();

        // 4: issue I,D,I,D then route in-order responses 1..4
        for (int k = 0; k < 4; k++) begin
            idle();
            if (k % 2 == 0) drv_inst(1'b1, 1'b0, 32'h40 + 32'(k), 32'h0);
            else            drv_data(1'b1, 1'b0, 32'h40 + 32'(k), 32'h0);
            m_if.addr_ok = 1'b1;
            #1;
            if (k % 2 == 0) chk("t4_inst_addr_ok", inst_if.addr_ok, 1);
            else            chk("t4_data_addr_ok", data_if.addr_ok, 1);
            step();
        end
        for (int k = 0; k < 4; k++) begin
            idle();
            drv_m(1'b0, 1'b1, 32'(k + 1));
            #1;
            chk("t4_inst_data_ok", inst_if.data_ok, (k % 2 == 0));
            chk("t4_data_data_ok", data_if.data_ok, (k % 2 == 1));
            if (k % 2 == 0) chk("t4_inst_rdata", inst_if.rdata, 32'(k + 1));
            else            chk("t4_data_rdata", data_if.rdata, 32'(k + 1));
            step();
        end
        idle();

        // 5: fill the owner FIFO, stall, free one slot
        for (int k = 0; k < 4; k++) begin
            drv_inst(1'b1, 1'b0, 32'h80 + 32'(k * 4), 32'h0);
            drv_m(1'b1, 1'b0, 32'h0);
            #1;
            chk("t5_fill_addr_ok", inst_if.addr_ok, 1);
            step();
        end
        drv_data(1'b1, 1'b0, 32'h90, 32'h0);
        #1;
        chk("t5_full_m_req", m_if.req, 0);
        chk("t5_full_inst_ok", inst_if.addr_ok, 0);
        chk("t5_full_data_ok", data_if.addr_ok, 0);
        step();
        drv_m(1'b1, 1'b1, 32'h5A);
        #1;
        chk("t5_pop_blocked", inst_if.addr_ok | data_if.addr_ok, 0);
        chk("t5_pop_inst_data_ok", inst_if.data_ok, 1);
        step();
        drv_data(1'b0, 1'b0, 32'h0, 32'h0);
        drv_m(1'b1, 1'b0, 32'h0);
        #1;
        chk("t5_accept_after", inst_if.addr_ok, 1);
        step();
        idle();
        for (int k = 0; k < 4; k++) begin
            drv_m(1'b0, 1'b1, 32'hC0 + 32'(k));
            #1;
            chk("t5_drain", inst_if.data_ok, 1);
            step();
        end
        idle();

        // 6: reset with two outstanding and a held lock
        drv_inst(1'b1, 1'b0, 32'hA00, 32'h0);
        drv_m(1'b1, 1'b0, 32'h0);
        step();
        drv_inst(1'b0, 1'b0, 32'h0, 32'h0);
        drv_data(1'b1, 1'b0, 32'hB00, 32'h0);
        step();
        drv_data(1'b1, 1'b0, 32'h7000, 32'h0);
        drv_m(1'b0, 1'b0, 32'h0);
        step();
        resetn = 1'b0;
        idle();
        drv_m(1'b0, 1'b1, 32'h99);
        #1;
        chk("t6_rst_inst_data_ok", inst_if.data_ok, 0);
        chk("t6_rst_data_data_ok", data_if.data_ok, 0);
        step();
        resetn = 1'b1;
        drv_m(1'b0, 1'b1, 32'h77);
        #1;
        chk("t6_orphan_inst", inst_if.data_ok, 0);
        chk("t6_orphan_data", data_if.data_ok, 0);
        step();
        idle();
        #1;
        chk("t6_err_orphan", dut.r_err_orphan, 1);
        drv_inst(1'b1, 1'b0, 32'h8000, 32'h0);
        drv_m(1'b1, 1'b0, 32'h0);
        #1;
        chk("t6_unlocked_grant", inst_if.addr_ok, 1);
        step();
        idle();
        drv_m(1'b0, 1'b1, 32'hABC);
        #1;
        chk("t6_post_rsp", inst_if.data_ok, 1);
        chk("t6_post_rdata", inst_if.rdata, 32'hABC);
        step();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
